id_ex_stage: RTL and testbench

- ID/EX pipeline register of the five-stage LEGv8 core. Sits directly downstream of the decode controller.
- Latches the controller's 9-bit control bus together with operands, immediate, PC, register numbers and the opcode field.
- Contains the load-use hazard detector. Inserts bubbles on load-use, hold and flush, and counts inserted bubbles for performance monitoring.

---
 rtl/id_ex_stage.sv | 138 +++++++++++++
 tb/tb_id_ex_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register of the five-stage LEGv8 core.
//
// Latches the decode control bus, operands, immediate, PC, register numbers
// and opcode field into the EX slot. It also detects load-use hazards
// against the instruction currently in EX. Bubbles are inserted on
// load-use, hold and flush, and a saturating counter records how many
// load-use bubbles have been inserted.
//
// Ports:
//   clk, reset_n            core clock, synchronous active-low reset
//   id_control              decode control bus
//                           [8] reg2loc [7:6] aluOp [5] aluSrc [4] branch
//                           [3] memRead [2] memWrite [1] regWrite [0] mem2reg
//   id_opcode               instruction[31:21]
//   id_pc, id_rdata1/2      PC and register read data
//   id_imm                  sign-extended immediate
//   id_rs1, id_rs2, id_rd   register numbers (rs2 already muxed by reg2loc)
//   id_uses_rs2             instruction actually reads rs2
//   id_valid                ID slot holds a real instruction
//   ex_hold                 downstream stall, freeze ID/EX
//   flush                   taken-branch squash
//   ex_*                    registered copies presented to EX
//   ex_valid                EX slot holds a real instruction
//   stall_if_id             combinational request for IF and IF/ID to hold
//   bubble_count            saturating count of load-use bubbles
module id_ex_stage #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 9,
    parameter int OPC_W  = 11,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [CTRL_W-1:0] id_control,
    input  logic [OPC_W-1:0]  id_opcode,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_valid,
    input  logic              ex_hold,
    input  logic              flush,
    output logic [CTRL_W-1:0] ex_control,
    output logic [OPC_W-1:0]  ex_opcode,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_valid,
    output logic              stall_if_id,
    output logic [CNT_W-1:0]  bubble_count
);

    // Register X31 reads as zero, so a load targeting it never creates a
    // dependency.
    localparam logic [REG_AW-1:0] XZR = '1;

    logic [CTRL_W-1:0] control_reg;
    logic [OPC_W-1:0]  opcode_reg;
    logic [DATA_W-1:0] pc_reg;
    logic [DATA_W-1:0] rdata1_reg;
    logic [DATA_W-1:0] rdata2_reg;
    logic [DATA_W-1:0] imm_reg;
    logic [REG_AW-1:0] rs1_reg;
    logic [REG_AW-1:0] rs2_reg;
    logic [REG_AW-1:0] rd_reg;
    logic              valid_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              hazard;

    // Control bit 3 is memRead: the instruction in EX is a load whose result
    // is not yet available to the instruction sitting in ID.
    assign hazard = valid_reg & control_reg[3] & id_valid & (rd_reg != XZR) &
                    ((rd_reg == id_rs1) | (id_uses_rs2 & (rd_reg == id_rs2)));

    // A flush squashes whatever is in ID, so IF/ID must be free to refill.
    assign stall_if_id = ~flush & (ex_hold | hazard);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            control_reg <= '0;
            opcode_reg  <= '0;
            pc_reg      <= '0;
            rdata1_reg  <= '0;
            rdata2_reg  <= '0;
            imm_reg     <= '0;
            rs1_reg     <= '0;
            rs2_reg     <= '0;
            rd_reg      <= '0;
            valid_reg   <= 1'b0;
            count_reg   <= '0;
        end else if (flush) begin
            // Data fields keep stale values; a zero control bus makes them inert.
            control_reg <= '0;
            valid_reg   <= 1'b0;
        end else if (ex_hold) begin
            // Freeze everything.
        end else if (hazard) begin
            control_reg <= '0;
            valid_reg   <= 1'b0;
            if (count_reg != '1) begin
                count_reg <= count_reg + 1'b1;
            end
        end else begin
            control_reg <= id_valid ? id_control : '0;
            opcode_reg  <= id_opcode;
            pc_reg      <= id_pc;
            rdata1_reg  <= id_rdata1;
            rdata2_reg  <= id_rdata2;
            imm_reg     <= id_imm;
            rs1_reg     <= id_rs1;
            rs2_reg     <= id_rs2;
            rd_reg      <= id_rd;
            valid_reg   <= id_valid;
        end
    end

    assign ex_control   = control_reg;
    assign ex_opcode    = opcode_reg;
    assign ex_pc        = pc_reg;
    assign ex_rdata1    = rdata1_reg;
    assign ex_rdata2    = rdata2_reg;
    assign ex_imm       = imm_reg;
    assign ex_rs1       = rs1_reg;
    assign ex_rs2       = rs2_reg;
    assign ex_rd        = rd_reg;
    assign ex_valid     = valid_reg;
    assign bubble_count = count_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam logic [8:0] C_ADD  = 9'b010000010;
    localparam logic [8:0] C_LDUR = 9'b000101011;
    localparam logic [8:0] C_CBZ  = 9'b100010000;
    localparam logic [8:0] C_B    = 9'b000010000;
    localparam int         SAT_W  = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [8:0]  id_control;
    logic [10:0] id_opcode;
    logic [63:0] id_pc, id_rdata1, id_rdata2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs2, id_valid, ex_hold, flush;

    logic [8:0]  ex_control;
    logic [10:0] ex_opcode;
    logic [63:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_valid, stall_if_id;
    logic [15:0] bubble_count;

    // Second copy with a narrow counter so saturation is reachable quickly.
    logic [8:0]  s_control;
    logic [10:0] s_opcode;
    logic [63:0] s_pc, s_rdata1, s_rdata2, s_imm;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic        s_valid, s_stall;
    logic [SAT_W-1:0] s_count;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_count;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset_n(reset_n), .id_control(id_control), .id_opcode(id_opcode),
        .id_pc(id_pc), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_valid(id_valid), .ex_hold(ex_hold), .flush(flush),
        .ex_control(ex_control), .ex_opcode(ex_opcode), .ex_pc(ex_pc),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_valid(ex_valid),
        .stall_if_id(stall_if_id), .bubble_count(bubble_count)
    );

    id_ex_stage #(.CNT_W(SAT_W)) dut_sat (
        .clk(clk), .reset_n(reset_n), .id_control(id_control), .id_opcode(id_opcode),
        .id_pc(id_pc), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_valid(id_valid), .ex_hold(ex_hold), .flush(flush),
        .ex_control(s_control), .ex_opcode(s_opcode), .ex_pc(s_pc),
        .ex_rdata1(s_rdata1), .ex_rdata2(s_rdata2), .ex_imm(s_imm),
        .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_valid(s_valid),
        .stall_if_id(s_stall), .bubble_count(s_count)
    );

    // Advance one clock; outputs are then examined 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [8:0] c, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic u);
        id_valid    = v;
        id_control  = c;
        id_rd       = rd;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_uses_rs2 = u;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ex_hold = 1'b0; flush = 1'b0;
        id_opcode = 11'h0; id_pc = 64'h0; id_rdata1 = 64'h0; id_rdata2 = 64'h0; id_imm = 64'h0;
        drive(1'b1, C_ADD, 5'd3, 5'd1, 5'd2, 1'b1);
        tick();
        tick();
        checks++; if (ex_control !== 9'h0) begin failures++; $display("FAIL reset_ctrl got=%b exp=%b", ex_control, 9'h0); end
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ex_valid); end
        checks++; if (bubble_count !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0000", bubble_count); end
        checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_if_id); end
        $display("reset: ctrl=%b valid=%b count=%0d", ex_control, ex_valid, bubble_count);
        reset_n = 1'b1;
        exp_count = 16'd0;
    endtask

    task automatic test_capture();
        id_rdata1 = 64'd5; id_rdata2 = 64'd7; id_opcode = 11'h458; id_pc = 64'h100; id_imm = 64'h2A;
        drive(1'b1, C_ADD, 5'd3, 5'd1, 5'd2, 1'b1);
        checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL cap_stall got=%b exp=0", stall_if_id); end
        tick();
        checks++; if (ex_control !== C_ADD) begin failures++; $display("FAIL cap_ctrl got=%b exp=%b", ex_control, C_ADD); end
        checks++; if (ex_rd !== 5'd3) begin failures++; $display("FAIL cap_rd got=%0d exp=3", ex_rd); end
        checks++; if (ex_rdata1 !== 64'd5) begin failures++; $display("FAIL cap_rdata1 got=%0d exp=5", ex_rdata1); end
        checks++; if (ex_rdata2 !== 64'd7) begin failures++; $display("FAIL cap_rdata2 got=%0d exp=7", ex_rdata2); end
        checks++; if (ex_opcode !== 11'h458) begin failures++; $display("FAIL cap_opcode got=%h exp=458", ex_opcode); end
        checks++; if (ex_pc !== 64'h100 || ex_imm !== 64'h2A) begin failures++; $display("FAIL cap_pc_imm got=%h/%h exp=100/2a", ex_pc, ex_imm); end
        checks++; if (ex_rs1 !== 5'd1 || ex_rs2 !== 5'd2) begin failures++; $display("FAIL cap_rs got=%0d/%0d exp=1/2", ex_rs1, ex_rs2); end
        checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL cap_valid got=%b exp=1", ex_valid); end
        $display("capture: ctrl=%b rd=%0d rdata1=%0d valid=%b", ex_control, ex_rd, ex_rdata1, ex_valid);
        // Invalid slot: data captured, control forced to zero.
        drive(1'b0, C_ADD, 5'd9, 5'd1, 5'd2, 1'b1);
        tick();
        checks++; if (ex_control !== 9'h0 || ex_valid !== 1'b0 || ex_rd !== 5'd9) begin
            failures++; $display("FAIL cap_invalid got=%b/%b/%0d exp=0/0/9", ex_control, ex_valid, ex_rd); end
        $display("capture invalid: ctrl=%b valid=%b rd=%0d", ex_control, ex_valid, ex_rd);
    endtask

    task automatic test_load_use();
        drive(1'b1, C_LDUR, 5'd4, 5'd2, 5'd0, 1'b0);
        tick();
        drive(1'b1, C_ADD, 5'd6, 5'd4, 5'd5, 1'b1);
        checks++; if (stall_if_id !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall_if_id); end
        tick();
        exp_count = exp_count + 16'd1;
        checks++; if (ex_control !== 9'h0 || ex_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%b/%b exp=0/0", ex_control, ex_valid); end
        checks++; if (bubble_count !== exp_count) begin failures++; $display("FAIL lu_count got=%0d exp=%0d", bubble_count, exp_count); end
        checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL lu_stall_release got=%b exp=0", stall_if_id); end
        tick();
        checks++; if (ex_control !== C_ADD || ex_rd !== 5'd6) begin failures++; $display("FAIL lu_capture got=%b/%0d exp=%b/6", ex_control, ex_rd, C_ADD); end
        $display("load-use rs1: ctrl=%b rd=%0d count=%0d", ex_control, ex_rd, bubble_count);
        // Dependency through rs2.
        drive(1'b1, C_LDUR, 5'd7, 5'd2, 5'd0, 1'b0);
        tick();
        drive(1'b1, C_ADD, 5'd8, 5'd1, 5'd7, 1'b1);
        checks++; if (stall_if_id !== 1'b1) begin failures++; $display("FAIL lu_rs2_stall got=%b exp=1", stall_if_id); end
        tick();
        exp_count = exp_count + 16'd1;
        checks++; if (bubble_count !== exp_count) begin failures++; $display("FAIL lu_rs2_count got=%0d exp=%0d", bubble_count, exp_count); end
        tick();
        checks++; if (ex_control !== C_ADD || ex_rd !== 5'd8) begin failures++; $display("FAIL lu_rs2_capture got=%b/%0d exp=%b/8", ex_control, ex_rd, C_ADD); end
        $display("load-use rs2: ctrl=%b rd=%0d count=%0d", ex_control, ex_rd, bubble_count);
    endtask

    task automatic test_no_false_hazard();
        drive(1'b1, C_LDUR, 5'd31, 5'd2, 5'd0, 1'b0);
        tick();
        drive(1'b1, C_ADD, 5'd6, 5'd31, 5'd1, 1'b1);
        checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL xzr_stall got=%b exp=0", stall_if_id); end
        tick();
        checks++; if (ex_control !== C_ADD || bubble_count !== exp_count) begin
            failures++; $display("FAIL xzr_capture got=%b/%0d exp=%b/%0d", ex_control, bubble_count, C_ADD, exp_count); end
        $display("xzr: stall=0 ctrl=%b count=%0d", ex_control, bubble_count);
        drive(1'b1, C_LDUR, 5'd4, 5'd2, 5'd0, 1'b0);
        tick();
        drive(1'b1, C_B, 5'd0, 5'd9, 5'd4, 1'b0);
        checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL nors2_stall got=%b exp=0", stall_if_id); end
        tick();
        checks++; if (ex_control !== C_B || bubble_count !== exp_count) begin
            failures++; $display("FAIL nors2_capture got=%b/%0d exp=%b/%0d", ex_control, bubble_count, C_B, exp_count); end
        $display("unused rs2: ctrl=%b count=%0d", ex_control, bubble_count);
    endtask

    task automatic test_flush_vs_hold();
        drive(1'b1, C_LDUR, 5'd4, 5'd2, 5'd0, 1'b0);
        tick();
        flush = 1'b1; ex_hold = 1'b1;
        drive(1'b1, C_CBZ, 5'd0, 5'd4, 5'd4, 1'b1);
        checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall_if_id); end
        tick();
        checks++; if (ex_control !== 9'h0 || ex_valid !== 1'b0) begin failures++; $display("FAIL flush_bubble got=%b/%b exp=0/0", ex_control, ex_valid); end
        checks++; if (bubble_count !== exp_count) begin failures++; $display("FAIL flush_count got=%0d exp=%0d", bubble_count, exp_count); end
        $display("flush+hold: ctrl=%b valid=%b count=%0d", ex_control, ex_valid, bubble_count);
        flush = 1'b0; ex_hold = 1'b0;
    endtask

    task automatic test_hold();
        id_rdata1 = 64'h1234; id_pc = 64'h40; id_imm = 64'h8;
        drive(1'b1, C_LDUR, 5'd4, 5'd10, 5'd0, 1'b0);
        tick();
        ex_hold = 1'b1;
        id_rdata1 = 64'hDEAD; id_pc = 64'h44; id_imm = 64'h0;
        drive(1'b1, C_ADD, 5'd11, 5'd4, 5'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++; if (stall_if_id !== 1'b1) begin failures++; $display("FAIL hold_stall[%0d] got=%b exp=1", i, stall_if_id); end
            tick();
            checks++; if (ex_control !== C_LDUR || ex_rd !== 5'd4 || ex_rdata1 !== 64'h1234 || ex_pc !== 64'h40 || ex_imm !== 64'h8) begin
                failures++; $display("FAIL hold_keep[%0d] got=%b/%0d/%h/%h exp=%b/4/1234/40", i, ex_control, ex_rd, ex_rdata1, ex_pc, C_LDUR); end
            checks++; if (bubble_count !== exp_count) begin failures++; $display("FAIL hold_count[%0d] got=%0d exp=%0d", i, bubble_count, exp_count); end
            $display("hold cycle %0d: ctrl=%b rd=%0d count=%0d", i, ex_control, ex_rd, bubble_count);
        end
        ex_hold = 1'b0;
        #1;
        tick();
        exp_count = exp_count + 16'd1;
        checks++; if (ex_control !== 9'h0 || bubble_count !== exp_count) begin
            failures++; $display("FAIL hold_release got=%b/%0d exp=0/%0d", ex_control, bubble_count, exp_count); end
        tick();
        checks++; if (ex_control !== C_ADD || ex_rdata1 !== 64'hDEAD) begin
            failures++; $display("FAIL hold_after got=%b/%h exp=%b/dead", ex_control, ex_rdata1, C_ADD); end
        $display("hold release: ctrl=%b count=%0d", ex_control, bubble_count);
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 9'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        for (int i = 0; i < (1 << SAT_W) + 5; i++) begin
            drive(1'b1, C_LDUR, 5'd4, 5'd2, 5'd0, 1'b0);
            tick();
            drive(1'b1, C_ADD, 5'd6, 5'd4, 5'd1, 1'b1);
            tick();
            exp_count = exp_count + 16'd1;
        end
        checks++; if (bubble_count !== exp_count) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", bubble_count, exp_count); end
        checks++; if (s_count !== 5'h1F) begin failures++; $display("FAIL sat_count got=%h exp=1f", s_count); end
        $display("back-to-back: count=%0d narrow_count=%0d", bubble_count, s_count);
        // Saturated counter must not wrap on further bubbles.
        drive(1'b1, C_LDUR, 5'd4, 5'd2, 5'd0, 1'b0);
        tick();
        drive(1'b1, C_ADD, 5'd6, 5'd4, 5'd1, 1'b1);
        tick();
        checks++; if (s_count !== 5'h1F) begin failures++; $display("FAIL sat_hold got=%h exp=1f", s_count); end
        $display("saturated: narrow_count=%0d", s_count);
    endtask

    task automatic test_reset_override();
        ex_hold = 1'b1; flush = 1'b1; reset_n = 1'b0;
        drive(1'b1, C_ADD, 5'd3, 5'd1, 5'd2, 1'b1);
        tick();
        checks++; if (bubble_count !== 16'h0 || ex_valid !== 1'b0 || ex_rd !== 5'd0 || ex_rdata1 !== 64'h0) begin
            failures++; $display("FAIL reset_override got=%0d/%b/%0d/%h exp=0/0/0/0", bubble_count, ex_valid, ex_rd, ex_rdata1); end
        $display("reset override: count=%0d valid=%b", bubble_count, ex_valid);
        reset_n = 1'b1; ex_hold = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_load_use();
        test_no_false_hazard();
        test_flush_vs_hold();
        test_hold();
        test_back_to_back();
        test_reset_override();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
